// File: rtl/axi_lite_control_pkg.sv
// axi_lite_control_pkg: register offsets, version ID and AXI constants for the control block
package axi_lite_control_pkg;
    localparam int CTRL     = 'h00;
    localparam int STATUS   = 'h04;
    localparam int CYCLES   = 'h08;
    localparam int ACC_MODE = 'h0C;
    localparam int VERSION  = 'h10;
    localparam int MULT     = 'h14;
    localparam int SHIFT    = 'h18;
    localparam int ZP       = 'h1C;
    localparam int BIAS     = 'h20;
    localparam logic [31:0] VERSION_ID_DEFAULT = 32'h2026_0116;
    localparam logic [1:0]  RESP_OKAY = 2'b00;

    function automatic logic [31:0] strb_merge(input logic [31:0] old, input logic [31:0] data,
                                               input logic [3:0] strb);
        logic [31:0] r;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = strb[i] ? data[8*i +: 8] : old[8*i +: 8];
        return r;
    endfunction
endpackage

// File: rtl/axi_lite_control.sv
// axi_lite_control: AXI4-Lite register file driving accelerator start, soft reset and PPU config
module axi_lite_control
    import axi_lite_control_pkg::*;
#(
    parameter int          ADDR_W     = 6,
    parameter logic [31:0] VERSION_ID = VERSION_ID_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic              o_ap_start,
    output logic              o_soft_rst_n,
    output logic [31:0]       o_cfg_compute_cycles,
    output logic              o_cfg_acc_mode,
    input  logic              i_ap_done,
    input  logic              i_ap_idle,
    output logic [15:0]       o_ppu_mult,
    output logic [4:0]        o_ppu_shift,
    output logic [7:0]        o_ppu_zp,
    output logic [31:0]       o_ppu_bias
);
    logic        ap_done;
    logic        wr_en, rd_en;
    logic        ctrl_wr, status_wr;
    logic [31:0] wm;
    int          wa;

    function automatic logic [31:0] reg_read(input logic [ADDR_W-1:0] a);
        int o = int'(a) & ~3;
        return o == CTRL     ? {30'b0, o_soft_rst_n, 1'b0} :
               o == STATUS   ? {30'b0, i_ap_idle, ap_done} :
               o == CYCLES   ? o_cfg_compute_cycles :
               o == ACC_MODE ? {31'b0, o_cfg_acc_mode} :
               o == VERSION  ? VERSION_ID :
               o == MULT     ? {16'b0, o_ppu_mult} :
               o == SHIFT    ? {27'b0, o_ppu_shift} :
               o == ZP       ? {24'b0, o_ppu_zp} :
               o == BIAS     ? o_ppu_bias : 32'b0;
    endfunction

    assign wa        = int'(s_axi_awaddr) & ~3;
    assign wr_en     = s_axi_awready && s_axi_awvalid && s_axi_wvalid;
    assign rd_en     = s_axi_arready && s_axi_arvalid;
    assign ctrl_wr   = wr_en && wa == CTRL && s_axi_wstrb[0];
    assign status_wr = wr_en && wa == STATUS && s_axi_wstrb[0];
    assign wm        = strb_merge(reg_read(s_axi_awaddr), s_axi_wdata, s_axi_wstrb);
    assign s_axi_bresp = RESP_OKAY;
    assign s_axi_rresp = RESP_OKAY;

    always_ff @(posedge clk) begin
        if (rst) begin
            s_axi_awready        <= 1'b0;
            s_axi_wready         <= 1'b0;
            s_axi_bvalid         <= 1'b0;
            s_axi_arready        <= 1'b0;
            s_axi_rvalid         <= 1'b0;
            s_axi_rdata          <= '0;
            o_ap_start           <= 1'b0;
            o_soft_rst_n         <= 1'b1;
            ap_done              <= 1'b0;
            o_cfg_compute_cycles <= '0;
            o_cfg_acc_mode       <= 1'b0;
            o_ppu_mult           <= '0;
            o_ppu_shift          <= '0;
            o_ppu_zp             <= '0;
            o_ppu_bias           <= '0;
        end else begin
            s_axi_awready <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            s_axi_wready  <= s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid && !s_axi_awready;
            s_axi_bvalid  <= wr_en || (s_axi_bvalid && !s_axi_bready);
            s_axi_arready <= s_axi_arvalid && !s_axi_rvalid && !s_axi_arready;
            s_axi_rvalid  <= rd_en || (s_axi_rvalid && !s_axi_rready);
            s_axi_rdata   <= rd_en ? reg_read(s_axi_araddr) : s_axi_rdata;
            o_ap_start    <= ctrl_wr && s_axi_wdata[0];
            o_soft_rst_n  <= ctrl_wr ? s_axi_wdata[1] : o_soft_rst_n;
            // a done pulse on the clearing edge must not be lost
            ap_done       <= i_ap_done || (ap_done && !(status_wr && s_axi_wdata[0]));
            if (wr_en) begin
                o_cfg_compute_cycles <= wa == CYCLES   ? wm        : o_cfg_compute_cycles;
                o_cfg_acc_mode       <= wa == ACC_MODE ? wm[0]     : o_cfg_acc_mode;
                o_ppu_mult           <= wa == MULT     ? wm[15:0]  : o_ppu_mult;
                o_ppu_shift          <= wa == SHIFT    ? wm[4:0]   : o_ppu_shift;
                o_ppu_zp             <= wa == ZP       ? wm[7:0]   : o_ppu_zp;
                o_ppu_bias           <= wa == BIAS     ? wm        : o_ppu_bias;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_control.sv
// tb_axi_lite_control: directed register-map checks for the AXI-Lite control block
module tb_axi_lite_control;
    logic        clk = 0, rst = 1;
    logic [5:0]  awaddr = 0, araddr = 0;
    logic        awvalid = 0, wvalid = 0, bready = 1, arvalid = 0, rready = 1;
    logic [31:0] wdata = 0;
    logic [3:0]  wstrb = 0;
    logic        awready, wready, bvalid, arready, rvalid;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        ap_start, soft_rst_n, acc_mode, ap_done = 0, ap_idle = 0;
    logic [31:0] cycles, bias;
    logic [15:0] mult;
    logic [4:0]  shift;
    logic [7:0]  zp;
    logic [31:0] rd;
    int checks = 0, errors = 0;

    axi_lite_control dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
        .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
        .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
        .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
        .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
        .o_ap_start(ap_start), .o_soft_rst_n(soft_rst_n),
        .o_cfg_compute_cycles(cycles), .o_cfg_acc_mode(acc_mode),
        .i_ap_done(ap_done), .i_ap_idle(ap_idle),
        .o_ppu_mult(mult), .o_ppu_shift(shift), .o_ppu_zp(zp), .o_ppu_bias(bias)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // returns at handshake edge + #1; done_hs drives i_ap_done on exactly that edge
    task automatic axi_write(input logic [5:0] a, input logic [31:0] d,
                             input logic [3:0] s = 4'hF, input logic done_hs = 1'b0);
        @(negedge clk);
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin
                check("wready_with_awready", {31'b0, wready}, 1);
                ap_done = done_hs;
                @(posedge clk); #1;
                awvalid = 0; wvalid = 0; ap_done = 0;
                check("bvalid_after_hs", {31'b0, bvalid}, 1);
                return;
            end
        end
        check("aw_timeout", 0, 1);
        awvalid = 0; wvalid = 0;
    endtask

    task automatic axi_read(input logic [5:0] a, output logic [31:0] d);
        d = 'x;
        @(negedge clk);
        araddr = a; arvalid = 1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin
                @(posedge clk); #1;
                arvalid = 0;
                check("rvalid_after_hs", {31'b0, rvalid}, 1);
                check("rresp", {30'b0, rresp}, 0);
                d = rdata;
                return;
            end
        end
        check("ar_timeout", 0, 1);
        arvalid = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_awready", {31'b0, awready}, 0);
        check("rst_bvalid", {31'b0, bvalid}, 0);
        check("rst_rvalid", {31'b0, rvalid}, 0);
        check("rst_rdata", rdata, 0);
        check("rst_ap_start", {31'b0, ap_start}, 0);
        check("rst_soft_rst_n", {31'b0, soft_rst_n}, 1);
        check("rst_cycles", cycles, 0);
        @(negedge clk) rst = 0;

        axi_read(6'h10, rd);  check("version", rd, 32'h2026_0116);

        axi_write(6'h08, 197); check("cycles_out", cycles, 197);
        check("bresp", {30'b0, bresp}, 0);
        axi_write(6'h0C, 1);   check("acc_out", {31'b0, acc_mode}, 1);
        axi_read(6'h08, rd);   check("cycles_rd", rd, 197);
        axi_read(6'h0C, rd);   check("acc_rd", rd, 1);

        axi_write(6'h00, 2);   check("soft_rst_n", {31'b0, soft_rst_n}, 1);
        check("no_start_on_bit0_0", {31'b0, ap_start}, 0);
        axi_write(6'h00, 1);   check("ap_start_pulse", {31'b0, ap_start}, 1);
        check("soft_rst_n_cleared", {31'b0, soft_rst_n}, 0);
        @(posedge clk); #1;    check("ap_start_cleared", {31'b0, ap_start}, 0);
        axi_read(6'h00, rd);   check("ctrl_rd", rd, 0);

        ap_idle = 1;
        @(negedge clk) ap_done = 1;
        @(negedge clk) ap_done = 0;
        axi_read(6'h04, rd);   check("status_done", rd, 3);
        axi_write(6'h04, 0);   axi_read(6'h04, rd); check("status_w0", rd, 3);
        axi_write(6'h04, 1);   axi_read(6'h04, rd); check("status_w1c", rd, 2);
        axi_write(6'h04, 1, 4'hF, 1'b1);
        axi_read(6'h04, rd);   check("status_set_wins", rd, 3);

        axi_write(6'h14, 32'h100);
        axi_write(6'h18, 32'h8);
        axi_write(6'h1C, 32'hA);
        axi_write(6'h20, 32'hFFFF_FF80);
        check("ppu_mult", {16'b0, mult}, 256);
        check("ppu_shift", {27'b0, shift}, 8);
        check("ppu_zp", {24'b0, zp}, 10);
        check("ppu_bias", bias, 32'hFFFF_FF80);
        axi_read(6'h20, rd);   check("bias_rd", rd, 32'hFFFF_FF80);

        axi_write(6'h08, 0);
        axi_write(6'h08, 32'hAABB_CCDD, 4'h3);
        axi_read(6'h08, rd);   check("wstrb_partial", rd, 32'h0000_CCDD);
        axi_write(6'h1C, 32'h1234_5655, 4'h2);
        axi_read(6'h1C, rd);   check("zp_lane_masked", rd, 32'h0A);

        bready = 0;
        axi_write(6'h0C, 0);
        @(negedge clk);
        awaddr = 6'h08; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bvalid_hold", {31'b0, bvalid}, 1);
            check("awready_blocked", {31'b0, awready}, 0);
        end
        bready = 1;
        axi_write(6'h08, 32'h55);
        axi_read(6'h08, rd);   check("second_write", rd, 32'h55);
        axi_read(6'h0C, rd);   check("first_write", rd, 0);

        axi_write(6'h24, 32'hDEAD_BEEF);
        axi_read(6'h24, rd);   check("unmapped_rd", rd, 0);
        axi_read(6'h10, rd);   check("version_ro", rd, 32'h2026_0116);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
